aes_inv_key_schedule: RTL and testbench

Sequential AES-128 inverse key scheduler for the SIMD processor's decryption path in the execute stage. It accepts the final round key (round 10) and walks the key schedule backwards one round per accepted output. It streams round keys 10 down to 0 over a valid/ready interface, which is the order InvCipher consumes them. It holds a private forward S-box and an Rcon table, with no shared-memory accesses.

---
 rtl/aes_inv_key_schedule_if.sv | 27 ++
 rtl/aes_inv_key_schedule.sv | 134 +++++++++++++
 tb/tb_aes_inv_key_schedule.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_key_schedule_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_inv_key_schedule_if : load/stream bundle for the inverse key scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
interface aes_inv_key_schedule_if;
  logic         start;
  logic [127:0] key_in;
  logic         out_ready;
  logic         out_valid;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_last;
  logic         busy;
  logic         done;

  modport master (
    output start, key_in, out_ready,
    input  out_valid, out_key, out_round, out_last, busy, done
  );

  modport slave (
    input  start, key_in, out_ready,
    output out_valid, out_key, out_round, out_last, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_inv_key_schedule : AES-128 key schedule walked backwards, round 10 -> 0
// Revision: 1.0
// ---------------------------------------------------------------------------
module aes_inv_key_schedule (
  input  logic                         clk,
  input  logic                         rst_n,
  aes_inv_key_schedule_if.slave        bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Forward S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd10:   return 8'h36;
      4'd9:    return 8'h1b;
      4'd8:    return 8'h80;
      4'd7:    return 8'h40;
      4'd6:    return 8'h20;
      4'd5:    return 8'h10;
      4'd4:    return 8'h08;
      4'd3:    return 8'h04;
      4'd2:    return 8'h02;
      4'd1:    return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   round_q, round_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         done_q, done_d;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w1_prev, w2_prev, w3_prev, w0_prev;
  logic [31:0]  rot_word, sub_word;
  logic [127:0] key_prev;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign w3_prev  = w3 ^ w2;
  assign w2_prev  = w2 ^ w1;
  assign w1_prev  = w1 ^ w0;
  assign rot_word = {w3_prev[23:0], w3_prev[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign sub_word[i*8 +: 8] = sbox(rot_word[i*8 +: 8]);
  end

  // Rcon is indexed by the round being left, i.e. the key currently presented
  assign w0_prev  = w0 ^ sub_word ^ {rcon(round_q), 24'h0};
  assign key_prev = {w0_prev, w1_prev, w2_prev, w3_prev};

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          key_d   = bus.key_in;
          round_d = 4'd10;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && bus.out_ready) begin
          if (round_q == 4'd0) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d   = key_prev;
            round_d = round_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    last_d = valid_d && (round_d == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_key   = key_q;
  assign bus.out_round = round_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aes_inv_key_schedule : directed and round-trip checks of the inverse schedule
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_inv_key_schedule_if bus ();
  aes_inv_key_schedule dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
    logic         last;
  } vec_t;

  vec_t         fips [0:10];
  logic [127:0] exp_keys [0:10];
  logic [7:0]   sbox_t [0:255];
  int           total = 0;
  int           bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in, b = b_in, p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from GF(2^8) inverse plus affine map, independent of any table
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Streams one full schedule with ready high and checks every key against exp_keys
  task automatic run_full(input logic [127:0] k10, input bit do_start, input int glitch_round,
                          input bit b2b, input logic [127:0] k_next);
    bus.out_ready = 1'b1;
    if (do_start) begin
      bus.start  = 1'b1;
      bus.key_in = k10;
      step();
      bus.start  = 1'b0;
    end
    for (int r = 10; r >= 0; r--) begin
      chk("valid", 128'(bus.out_valid), 128'(1));
      chk("round", 128'(bus.out_round), 128'(r));
      chk("key", bus.out_key, exp_keys[r]);
      chk("last", 128'(bus.out_last), 128'(r == 0));
      chk("busy", 128'(bus.busy), 128'(1));
      chk("done_low", 128'(bus.done), 128'(0));
      bus.start  = (r == glitch_round);
      bus.key_in = (r == glitch_round) ? {128{1'b1}} : k10;
      step();
      bus.start = 1'b0;
    end
    chk("done_pulse", 128'(bus.done), 128'(1));
    chk("busy_fall", 128'(bus.busy), 128'(0));
    chk("valid_fall", 128'(bus.out_valid), 128'(0));
    if (b2b) begin
      bus.start  = 1'b1;
      bus.key_in = k_next;
      step();
      bus.start  = 1'b0;
    end else begin
      step();
      chk("done_once", 128'(bus.done), 128'(0));
      chk("valid_idle", 128'(bus.out_valid), 128'(0));
    end
  endtask

  initial begin
    logic [127:0] hold_k;
    logic [3:0]   hold_r;
    logic [127:0] ck;
    int           idx, cyc, stalls;
    bit           stalled;

    fips[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1};
    fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b0};
    fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f, 1'b0};
    fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b, 1'b0};
    fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00, 1'b0};
    fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc, 1'b0};
    fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd, 1'b0};
    fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f, 1'b0};
    fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f, 1'b0};
    fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e, 1'b0};
    fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0};

    bus.start = 1'b0;
    bus.key_in = '0;
    bus.out_ready = 1'b0;
    build_sbox();

    // Reset values
    #1;
    chk("rst_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_key", bus.out_key, 128'h0);
    chk("rst_round", 128'(bus.out_round), 128'(0));
    chk("rst_last", 128'(bus.out_last), 128'(0));
    chk("rst_busy", 128'(bus.busy), 128'(0));
    chk("rst_done", 128'(bus.done), 128'(0));
    step();
    step();
    rst_n = 1'b1;

    // Ready while idle has no effect
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_valid", 128'(bus.out_valid), 128'(0));
    end

    // FIPS-197 table, ready held high
    bus.start = 1'b1;
    bus.key_in = fips[10].key;
    step();
    bus.start = 1'b0;
    for (int i = 10; i >= 0; i--) begin
      chk("fips_valid", 128'(bus.out_valid), 128'(1));
      chk("fips_round", 128'(bus.out_round), 128'(fips[i].round));
      chk("fips_key", bus.out_key, fips[i].key);
      chk("fips_last", 128'(bus.out_last), 128'(fips[i].last));
      step();
    end
    chk("fips_done", 128'(bus.done), 128'(1));
    step();
    chk("fips_done_once", 128'(bus.done), 128'(0));

    for (int r = 0; r <= 10; r++) exp_keys[r] = fips[r].key;

    // start pulsed with all-ones key while presenting round 6
    run_full(fips[10].key, 1'b1, 6, 1'b0, '0);

    // Random backpressure
    bus.start = 1'b1;
    bus.key_in = fips[10].key;
    step();
    bus.start = 1'b0;
    idx = 10; cyc = 0; stalls = 0; stalled = 1'b0;
    while (!bus.done && cyc < 300) begin
      if (stalled) begin
        chk("bp_hold_key", bus.out_key, hold_k);
        chk("bp_hold_round", 128'(bus.out_round), 128'(hold_r));
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      cyc++;
      if (bus.out_ready) begin
        chk("bp_valid", 128'(bus.out_valid), 128'(1));
        chk("bp_round", 128'(bus.out_round), 128'(idx < 0 ? 0 : idx));
        chk("bp_key", bus.out_key, exp_keys[idx < 0 ? 0 : idx]);
        idx--;
        stalled = 1'b0;
      end else begin
        stalls++;
        stalled = 1'b1;
        hold_k = bus.out_key;
        hold_r = bus.out_round;
      end
      step();
    end
    chk("bp_done", 128'(bus.done), 128'(1));
    chk("bp_count", 128'(idx + 1), 128'(0));
    chk("bp_cycles", 128'(cyc), 128'(11 + stalls));
    bus.out_ready = 1'b1;
    step();

    // Reset while round 4 is presented
    bus.start = 1'b1;
    bus.key_in = fips[10].key;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mr_round4", 128'(bus.out_round), 128'(4));
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 128'(bus.out_valid), 128'(0));
    chk("mr_key", bus.out_key, 128'h0);
    chk("mr_round", 128'(bus.out_round), 128'(0));
    chk("mr_busy", 128'(bus.busy), 128'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mr_no_done", 128'(bus.done), 128'(0));
      chk("mr_no_valid", 128'(bus.out_valid), 128'(0));
    end
    run_full(fips[10].key, 1'b1, -1, 1'b0, '0);

    // Back-to-back: second start in the done cycle
    ck = {$urandom, $urandom, $urandom, $urandom};
    expand(ck);
    hold_k = exp_keys[10];
    for (int r = 0; r <= 10; r++) exp_keys[r] = fips[r].key;
    run_full(fips[10].key, 1'b1, -1, 1'b1, hold_k);
    expand(ck);
    run_full(hold_k, 1'b0, -1, 1'b0, '0);

    // Round trip against forward expansion
    for (int n = 0; n < 1000; n++) begin
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand(ck);
      run_full(exp_keys[10], 1'b1, -1, 1'b0, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
